// File: rtl/reg_file_pkg.sv
// Shared defaults and the address type for the scoreboarded register file.
package reg_file_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 4;

  typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback bus of the register file; master is the pipeline, slave is the file.
interface reg_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  localparam int NREGS = 2**ADDR_W;

  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              rd_busy1;
  logic              rd_busy2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_addr;
  logic              issue_stall;
  logic              flush;
  logic [NREGS-1:0]  busy_vec;
  logic [ADDR_W:0]   pend_cnt;

  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
    input  rd_data1, rd_data2, rd_busy1, rd_busy2, issue_stall, busy_vec, pend_cnt
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
    output rd_data1, rd_data2, rd_busy1, rd_busy2, issue_stall, busy_vec, pend_cnt
  );

endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register busy tracking: issue marks a destination busy, writeback clears it,
// flush clears everything. Also produces the WAW stall and the pending count.
module reg_scoreboard import reg_file_pkg::*; #(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wrEn_i,
  input  logic [ADDR_W-1:0]    wrAddr_i,
  input  logic                 issueEn_i,
  input  logic [ADDR_W-1:0]    issueAddr_i,
  input  logic                 flush_i,
  input  logic [ADDR_W-1:0]    rdAddr1_i,
  input  logic [ADDR_W-1:0]    rdAddr2_i,
  output logic                 issueStall_o,
  output logic                 rdBusy1_o,
  output logic                 rdBusy2_o,
  output logic [2**ADDR_W-1:0] busyVec_o,
  output logic [ADDR_W:0]      pendCnt_o
);

  localparam int NREGS = 2**ADDR_W;

  logic [NREGS-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  pendCnt_q, pendCnt_d;
  logic             clrHit;
  logic             zeroIssue;
  logic             issueAccept;

  // A writeback landing on the issue target this cycle frees it, so no stall.
  always_comb begin
    clrHit       = wrEn_i && (wrAddr_i == issueAddr_i);
    zeroIssue    = ZERO_REG && (issueAddr_i == '0);
    issueStall_o = issueEn_i && busy_q[issueAddr_i] && !clrHit && !zeroIssue;
    issueAccept  = issueEn_i && !issueStall_o && !flush_i && !zeroIssue;
  end

  always_comb begin
    busy_d    = busy_q;
    pendCnt_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (flush_i) begin
        busy_d[i] = 1'b0;
      end else if (issueAccept && (issueAddr_i == ADDR_W'(i))) begin
        busy_d[i] = 1'b1;
      end else if (wrEn_i && (wrAddr_i == ADDR_W'(i))) begin
        busy_d[i] = 1'b0;
      end
      pendCnt_d = pendCnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= '0;
      pendCnt_q <= '0;
    end else begin
      busy_q    <= busy_d;
      pendCnt_q <= pendCnt_d;
    end
  end

  always_comb begin
    rdBusy1_o = busy_q[rdAddr1_i] && !(BYPASS && wrEn_i && (wrAddr_i == rdAddr1_i));
    rdBusy2_o = busy_q[rdAddr2_i] && !(BYPASS && wrEn_i && (wrAddr_i == rdAddr2_i));
    busyVec_o = busy_q;
    pendCnt_o = pendCnt_q;
  end

endmodule

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with optional write bypass and zero register,
// fronting a busy-bit scoreboard for hazard detection in decode.
module reg_file_sb import reg_file_pkg::*; #(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_file_sb_if.slave  bus
);

  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] regArray_q [NREGS];
  logic              wrAccept;

  assign wrAccept = bus.wr_en && !(ZERO_REG && (bus.wr_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regArray_q[i] <= '0;
      end
    end else if (wrAccept) begin
      regArray_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Zero register wins over bypass, bypass wins over the stored value.
  always_comb begin
    bus.rd_data1 = regArray_q[bus.rd_addr1];
    bus.rd_data2 = regArray_q[bus.rd_addr2];
    if (BYPASS && wrAccept && (bus.wr_addr == bus.rd_addr1)) begin
      bus.rd_data1 = bus.wr_data;
    end
    if (BYPASS && wrAccept && (bus.wr_addr == bus.rd_addr2)) begin
      bus.rd_data2 = bus.wr_data;
    end
    if (ZERO_REG && (bus.rd_addr1 == '0)) begin
      bus.rd_data1 = '0;
    end
    if (ZERO_REG && (bus.rd_addr2 == '0)) begin
      bus.rd_data2 = '0;
    end
  end

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .wrEn_i       (bus.wr_en),
    .wrAddr_i     (bus.wr_addr),
    .issueEn_i    (bus.issue_en),
    .issueAddr_i  (bus.issue_addr),
    .flush_i      (bus.flush),
    .rdAddr1_i    (bus.rd_addr1),
    .rdAddr2_i    (bus.rd_addr2),
    .issueStall_o (bus.issue_stall),
    .rdBusy1_o    (bus.rd_busy1),
    .rdBusy2_o    (bus.rd_busy2),
    .busyVec_o    (bus.busy_vec),
    .pendCnt_o    (bus.pend_cnt)
  );

endmodule
